// File: rtl/rtc_bus_pkg.sv
// Shared constants and helpers for the RTC bus responder.
//   - default register addresses
//   - BCD field limits
//   - a_d phase encoding
//   - BCD increment / wrap helpers used by the time base
package rtc_bus_pkg;

    localparam logic [7:0] ADDR_CTRL_DEF = 8'h00;
    localparam logic [7:0] ADDR_SEG_DEF  = 8'h21;
    localparam logic [7:0] ADDR_MIN_DEF  = 8'h22;
    localparam logic [7:0] ADDR_HORA_DEF = 8'h23;

    localparam logic [7:0] LIM_SEG_MIN = 8'h59;
    localparam logic [7:0] LIM_HORA    = 8'h23;

    localparam logic A_D_ADDR = 1'b0;
    localparam logic A_D_DATA = 1'b1;

    // Anything at or above the limit (including invalid BCD written by the
    // host) wraps to zero, so a corrupted field recovers on its next tick.
    function automatic logic bcd_wraps(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v >= lim)
            return 8'h00;
        else if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return v + 8'd1;
    endfunction

endpackage

// File: rtl/rtc_bus_sync.sv
// Strobe synchronisers for the RTC bus responder.
// Ports:
//   clk, reset         system clock, async active-low reset
//   a_d, cs, rd, wr    raw bus strobes (cs/rd/wr active low)
//   dato_in            raw bus value
//   a_d_s..wr_s        synchronised strobe levels
//   wr_rise            one-clk pulse on synchronised wr rising edge
//   dato_s             bus value delayed to line up with the synchronised strobes
module rtc_bus_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_d,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] dato_in,
    output logic       a_d_s,
    output logic       cs_s,
    output logic       rd_s,
    output logic       wr_s,
    output logic       wr_rise,
    output logic [7:0] dato_s
);

    logic       a_d_m, cs_m, rd_m, wr_m, wr_d;
    logic [7:0] dato_m;

    // Strobes reset to their idle levels so no edge is seen coming out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_d_m  <= 1'b0;
            a_d_s  <= 1'b0;
            cs_m   <= 1'b1;
            cs_s   <= 1'b1;
            rd_m   <= 1'b1;
            rd_s   <= 1'b1;
            wr_m   <= 1'b1;
            wr_s   <= 1'b1;
            wr_d   <= 1'b1;
            dato_m <= 8'h00;
            dato_s <= 8'h00;
        end else begin
            a_d_m  <= a_d;
            a_d_s  <= a_d_m;
            cs_m   <= cs;
            cs_s   <= cs_m;
            rd_m   <= rd;
            rd_s   <= rd_m;
            wr_m   <= wr;
            wr_s   <= wr_m;
            wr_d   <= wr_s;
            dato_m <= dato_in;
            dato_s <= dato_m;
        end
    end

    assign wr_rise = wr_s & ~wr_d;

endmodule

// File: rtl/rtc_bus_responder.sv
// RTC device on the multiplexed parallel RTC bus: address/data phases on
// dato, BCD seconds/minutes/hours time base and a control register (bit0 halt).
// Ports:
//   clk, reset                  system clock, async active-low reset
//   reg_a_d                     0 = address phase, 1 = data phase
//   reg_cs, reg_rd, reg_wr      active-low chip select / read / write strobes
//   dato                        bidirectional bus, driven only during a valid read
//   out_seg, out_min, out_hora  current time (BCD)
//   tick_1s                     one-clk pulse at every prescaler wrap
module rtc_bus_responder
    import rtc_bus_pkg::*;
#(
    parameter int         TICK_DIV  = 100000000,
    parameter logic [7:0] ADDR_CTRL = ADDR_CTRL_DEF,
    parameter logic [7:0] ADDR_SEG  = ADDR_SEG_DEF,
    parameter logic [7:0] ADDR_MIN  = ADDR_MIN_DEF,
    parameter logic [7:0] ADDR_HORA = ADDR_HORA_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reg_a_d,
    input  logic       reg_cs,
    input  logic       reg_rd,
    input  logic       reg_wr,
    inout  wire  [7:0] dato,
    output logic [7:0] out_seg,
    output logic [7:0] out_min,
    output logic [7:0] out_hora,
    output logic       tick_1s
);

    localparam int             CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

    logic          a_d_s, cs_s, rd_s, wr_s, wr_rise;
    logic [7:0]    dato_s;
    logic [CW-1:0] cnt;
    logic [7:0]    addr_q, ctrl_q, seg_q, min_q, hora_q;
    logic [7:0]    rd_mux, rd_q;
    logic          drive_q, adv_pend;
    logic          wrap, commit, adv_req;

    rtc_bus_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .a_d     (reg_a_d),
        .cs      (reg_cs),
        .rd      (reg_rd),
        .wr      (reg_wr),
        .dato_in (dato),
        .a_d_s   (a_d_s),
        .cs_s    (cs_s),
        .rd_s    (rd_s),
        .wr_s    (wr_s),
        .wr_rise (wr_rise),
        .dato_s  (dato_s)
    );

    assign wrap    = (cnt == CNT_LAST);
    assign commit  = wr_rise & ~cs_s & rd_s;
    // A tick that lands on a commit is held over one clk so it acts on the
    // freshly written values instead of being lost.
    assign adv_req = wrap | adv_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            tick_1s <= 1'b0;
        end else begin
            cnt     <= wrap ? '0 : cnt + CW'(1);
            tick_1s <= wrap;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= 8'h00;
            ctrl_q   <= 8'h00;
            seg_q    <= 8'h00;
            min_q    <= 8'h00;
            hora_q   <= 8'h00;
            adv_pend <= 1'b0;
        end else if (commit) begin
            adv_pend <= adv_req;
            if (a_d_s == A_D_ADDR) begin
                addr_q <= dato_s;
            end else begin
                case (addr_q)
                    ADDR_CTRL: ctrl_q <= dato_s;
                    ADDR_SEG:  seg_q  <= dato_s;
                    ADDR_MIN:  min_q  <= dato_s;
                    ADDR_HORA: hora_q <= dato_s;
                    default:   ;
                endcase
            end
        end else begin
            adv_pend <= 1'b0;
            if (adv_req && !ctrl_q[0]) begin
                seg_q <= bcd_inc(seg_q, LIM_SEG_MIN);
                if (bcd_wraps(seg_q, LIM_SEG_MIN)) begin
                    min_q <= bcd_inc(min_q, LIM_SEG_MIN);
                    if (bcd_wraps(min_q, LIM_SEG_MIN))
                        hora_q <= bcd_inc(hora_q, LIM_HORA);
                end
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr_q)
            ADDR_CTRL: rd_mux = ctrl_q;
            ADDR_SEG:  rd_mux = seg_q;
            ADDR_MIN:  rd_mux = min_q;
            ADDR_HORA: rd_mux = hora_q;
            default:   rd_mux = 8'h00;
        endcase
    end

    // Drive only for a clean data-phase read; rd and wr low together never drives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drive_q <= 1'b0;
            rd_q    <= 8'h00;
        end else begin
            drive_q <= ~cs_s & ~rd_s & wr_s & (a_d_s == A_D_DATA);
            rd_q    <= rd_mux;
        end
    end

    assign dato     = drive_q ? rd_q : 8'hzz;
    assign out_seg  = seg_q;
    assign out_min  = min_q;
    assign out_hora = hora_q;

endmodule
